uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//  Receive half of the UART link; the far-end partner of UART_Tx. Shares the BaudRate_generator tick (16x oversample).
//  Synchronises the serial line, detects and qualifies the start bit, and samples N_bits data bits LSB-first at mid-bit.
//  Checks the stop bit, then presents the byte with a one-cycle done pulse or flags a framing error.
//  Its output feeds the crypto accelerator input path.
// PARAMETERS
//  OVERSAMPLE  16  ticks per bit period; Baudrate=54 @100 MHz gives 115200 baud
//  DATA_MAX    8   widest data field supported; sets width of Message_out
// PORTS
//  clock        in   1   single system clock, rising edge
//  reset        in   1   synchronous, active-high
//  Tick_in      in   1   1-cycle oversample strobe from BaudRate_generator
//  N_bits       in   4   data bits per frame; legal 5..8, any other value = 8
//  Rx_in        in   1   asynchronous serial line, idle high
//  Message_out  out  8   last good byte, right-justified, upper bits 0
//  Rx_done      out  1   1-cycle pulse: Message_out updated with good frame
//  Frame_err    out  1   1-cycle pulse: stop bit sampled low
//  Rx_busy      out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, tick/bit counters 0, synchroniser flops preset to 1 (no false start).
//  Rx_in passes through a 2-flop synchroniser; FSM uses only rx_s. Line-to-FSM latency is 2 clocks.
//  Counters advance only on clocks where Tick_in=1. Between ticks the FSM holds state.
//  IDLE: rx_s=0 (no tick needed) -> START; clear tick_cnt; latch N_bits into nb_q.
//  START: at tick_cnt=OVERSAMPLE/2-1 (7), sample rx_s.
//    rx_s=0 -> DATA, clear tick_cnt and bit_cnt.
//    rx_s=1 -> glitch, back to IDLE; no pulse.
//  DATA: at tick_cnt=OVERSAMPLE-1 (15), write shreg[bit_cnt]<=rx_s, bit_cnt++, tick_cnt<=0.
//    After bit nb_q-1 -> STOP. Bits at or above nb_q stay 0.
//  STOP: at tick_cnt=15, sample rx_s.
//    rx_s=1 -> Message_out<=shreg, Rx_done=1 for next clock, -> IDLE.
//    rx_s=0 -> Frame_err=1 for next clock, Message_out unchanged, -> WAIT_IDLE.
//  WAIT_IDLE: remain until rx_s=1 (break or stuck line), then -> IDLE. Prevents re-triggering on a low line.
//  Rx_done and Frame_err are mutually exclusive and never high two clocks in a row.
//  Message_out holds its value until the next good frame.
//  Back-to-back frames: a start edge right after stop is caught because STOP returns to IDLE mid stop bit.
//  N_bits changes mid-frame are ignored (nb_q is used). Tick_in during reset is ignored.
//  Reset mid-frame: immediate return to IDLE, no pulse, Message_out cleared.
//  Widths: tick_cnt = $clog2(OVERSAMPLE) bits, bit_cnt 4 bits. All compares are unsigned.
// STRUCTURE
//  Shared include uart_defs.vh holds:
//    FSM state encodings IDLE/START/DATA/STOP/WAIT_IDLE (3-bit);
//    OVERSAMPLE default; N_bits legal range and clamp value.
//  Sub-module uart_sync2 is the 2-flop synchroniser with reset value 1; it can be reused for the Button input.
//  FSM, counters and shift register stay in uart_rx.
// TESTING
//  Bench: clock 10 ns, Baudrate=54, Rx_in driven by a UART_Tx instance in loopback.
//  1 Loopback: N_bits=8, send 8'h75 -> single Rx_done pulse, Message_out=8'h75, Frame_err stays 0.
//  2 Back-to-back: send 8'h75 then 8'h52 with no idle gap -> two Rx_done pulses, values 75 then 52.
//  3 Glitch: force Rx_in low for 3 ticks then high -> no Rx_done or Frame_err; Rx_busy returns to 0 within 8 ticks.
//  4 Framing: send 8'hA5 with stop bit forced 0, hold line low 40 ticks -> Frame_err pulse, Message_out keeps old value,
//    no new frame is accepted until the line goes high.
//  5 Short frame: N_bits=5, send 5'h15 -> Message_out=8'h15.
//    Also N_bits=4'hF, send 8'hC3 -> 8'hC3 (clamped to 8 bits).
//  6 Reset in DATA at bit 3 -> Message_out=0, Rx_busy=0 next clock; a following 8'h52 frame is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encodings, defaults and data-width clamp for the UART receiver
package uart_rx_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_MAX_DEF   = 8;
    localparam int NB_MIN         = 5;
    localparam int NB_MAX         = 8;
    localparam int NB_CLAMP       = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } rx_state_t;

    // Out-of-range widths fall back to a full byte so a bad setting never truncates data.
    function automatic logic [3:0] clamp_nbits(input logic [3:0] n);
        return (n >= 4'(NB_MIN) && n <= 4'(NB_MAX)) ? n : 4'(NB_CLAMP);
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchroniser for asynchronous single-bit inputs
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampled UART receiver with start qualification and framing check
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_MAX   = DATA_MAX_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                Tick_in,
    input  logic [3:0]          N_bits,
    input  logic                Rx_in,
    output logic [DATA_MAX-1:0] Message_out,
    output logic                Rx_done,
    output logic                Frame_err,
    output logic                Rx_busy
);

    localparam int TW   = $clog2(OVERSAMPLE);
    localparam int IDXW = $clog2(DATA_MAX);
    localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    rx_state_t state, state_d;

    logic                rx_s;
    logic [TW-1:0]       tick_cnt;
    logic [3:0]          bit_cnt;
    logic [3:0]          nb_q;
    logic [DATA_MAX-1:0] shreg;

    logic start_frame, enter_data, sample_bit, tick_inc, good_frame, bad_frame;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (Rx_in),
        .q     (rx_s)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d     = state;
        start_frame = 1'b0;
        enter_data  = 1'b0;
        sample_bit  = 1'b0;
        tick_inc    = 1'b0;
        good_frame  = 1'b0;
        bad_frame   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d     = ST_START;
                    start_frame = 1'b1;
                end
            end
            ST_START: begin
                if (Tick_in) begin
                    if (tick_cnt == TICK_HALF) begin
                        // A line that is high again at mid start bit was only a glitch.
                        if (!rx_s) begin
                            state_d    = ST_DATA;
                            enter_data = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (Tick_in) begin
                    if (tick_cnt == TICK_LAST) begin
                        sample_bit = 1'b1;
                        if (bit_cnt == nb_q - 4'd1) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (Tick_in) begin
                    if (tick_cnt == TICK_LAST) begin
                        if (rx_s) begin
                            good_frame = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            bad_frame = 1'b1;
                            state_d   = ST_WAIT_IDLE;
                        end
                    end else begin
                        tick_inc = 1'b1;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            nb_q        <= '0;
            shreg       <= '0;
            Message_out <= '0;
            Rx_done     <= 1'b0;
            Frame_err   <= 1'b0;
        end else begin
            Rx_done   <= good_frame;
            Frame_err <= bad_frame;
            if (start_frame) begin
                tick_cnt <= '0;
                nb_q     <= clamp_nbits(N_bits);
            end else if (enter_data) begin
                // Clearing here keeps bits above the frame width at zero.
                tick_cnt <= '0;
                bit_cnt  <= '0;
                shreg    <= '0;
            end else if (sample_bit) begin
                shreg[bit_cnt[IDXW-1:0]] <= rx_s;
                bit_cnt                  <= bit_cnt + 4'd1;
                tick_cnt                 <= '0;
            end else if (tick_inc) begin
                tick_cnt <= tick_cnt + 1'b1;
            end
            if (good_frame) begin
                Message_out <= shreg;
            end
        end
    end

    assign Rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx with a behavioural serial transmitter
module tb_uart_rx;

    localparam int TICK_DIV = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       Tick_in = 1'b0;
    logic [3:0] N_bits = 4'd8;
    logic       Rx_in = 1'b1;
    logic [7:0] Message_out;
    logic       Rx_done;
    logic       Frame_err;
    logic       Rx_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] done_q[$];
    int         ferr_cnt = 0;
    int         viol_cnt = 0;
    logic       prev_pulse = 1'b0;

    uart_rx dut (
        .clock       (clock),
        .reset       (reset),
        .Tick_in     (Tick_in),
        .N_bits      (N_bits),
        .Rx_in       (Rx_in),
        .Message_out (Message_out),
        .Rx_done     (Rx_done),
        .Frame_err   (Frame_err),
        .Rx_busy     (Rx_busy)
    );

    always #5 clock = ~clock;

    initial begin
        int c;
        c = 0;
        forever begin
            @(negedge clock);
            Tick_in = (c == TICK_DIV - 1);
            c = (c + 1) % TICK_DIV;
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            if (Rx_done) done_q.push_back(Message_out);
            if (Frame_err) ferr_cnt++;
            if (Rx_done && Frame_err) viol_cnt++;
            if ((Rx_done || Frame_err) && prev_pulse) viol_cnt++;
            prev_pulse = Rx_done || Frame_err;
        end
    end

    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clock);
            if (Tick_in) k++;
        end
        @(negedge clock);
    endtask

    function automatic int eff_nb(input int n);
        return (n >= 5 && n <= 8) ? n : 8;
    endfunction

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic stop_val, input int mid_nb);
        Rx_in = 1'b0;
        wait_ticks(16);
        if (mid_nb >= 0) N_bits = 4'(mid_nb);
        for (int i = 0; i < nbits; i++) begin
            Rx_in = data[i];
            wait_ticks(16);
        end
        Rx_in = stop_val;
        wait_ticks(16);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (6) @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++; if (Message_out !== 8'h00) begin n_fail++; $display("FAIL reset_msg got=%h exp=00", Message_out); end
        n_cmp++; if (Rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", Rx_done); end
        n_cmp++; if (Frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr got=%b exp=0", Frame_err); end
        n_cmp++; if (Rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", Rx_busy); end
    endtask

    task automatic test_loopback();
        int base, fb;
        base = done_q.size(); fb = ferr_cnt;
        N_bits = 4'd8;
        send_frame(8'h75, 8, 1'b1, -1);
        wait_ticks(4);
        n_cmp++; if (done_q.size() !== base + 1) begin n_fail++; $display("FAIL loop_count got=%0d exp=%0d", done_q.size(), base + 1); end
        else begin
            n_cmp++; if (done_q[base] !== 8'h75) begin n_fail++; $display("FAIL loop_data got=%h exp=75", done_q[base]); end
        end
        n_cmp++; if (Message_out !== 8'h75) begin n_fail++; $display("FAIL loop_hold got=%h exp=75", Message_out); end
        n_cmp++; if (ferr_cnt !== fb) begin n_fail++; $display("FAIL loop_ferr got=%0d exp=%0d", ferr_cnt, fb); end
        n_cmp++; if (Rx_busy !== 1'b0) begin n_fail++; $display("FAIL loop_busy got=%b exp=0", Rx_busy); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = done_q.size();
        send_frame(8'h75, 8, 1'b1, -1);
        send_frame(8'h52, 8, 1'b1, -1);
        wait_ticks(4);
        n_cmp++; if (done_q.size() !== base + 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=%0d", done_q.size(), base + 2); end
        else begin
            n_cmp++; if (done_q[base] !== 8'h75) begin n_fail++; $display("FAIL b2b_first got=%h exp=75", done_q[base]); end
            n_cmp++; if (done_q[base + 1] !== 8'h52) begin n_fail++; $display("FAIL b2b_second got=%h exp=52", done_q[base + 1]); end
        end
    endtask

    task automatic test_glitch();
        int base, fb;
        base = done_q.size(); fb = ferr_cnt;
        Rx_in = 1'b0;
        wait_ticks(3);
        n_cmp++; if (Rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_on got=%b exp=1", Rx_busy); end
        Rx_in = 1'b1;
        wait_ticks(8);
        n_cmp++; if (Rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_off got=%b exp=0", Rx_busy); end
        n_cmp++; if (done_q.size() !== base) begin n_fail++; $display("FAIL glitch_done got=%0d exp=%0d", done_q.size(), base); end
        n_cmp++; if (ferr_cnt !== fb) begin n_fail++; $display("FAIL glitch_ferr got=%0d exp=%0d", ferr_cnt, fb); end
    endtask

    task automatic test_framing();
        int base, fb;
        base = done_q.size(); fb = ferr_cnt;
        send_frame(8'hA5, 8, 1'b0, -1);
        wait_ticks(40);
        n_cmp++; if (ferr_cnt !== fb + 1) begin n_fail++; $display("FAIL frame_err got=%0d exp=%0d", ferr_cnt, fb + 1); end
        n_cmp++; if (done_q.size() !== base) begin n_fail++; $display("FAIL frame_done got=%0d exp=%0d", done_q.size(), base); end
        n_cmp++; if (Message_out !== 8'h52) begin n_fail++; $display("FAIL frame_hold got=%h exp=52", Message_out); end
        n_cmp++; if (Rx_busy !== 1'b1) begin n_fail++; $display("FAIL frame_wait_busy got=%b exp=1", Rx_busy); end
        Rx_in = 1'b1;
        wait_ticks(2);
        n_cmp++; if (Rx_busy !== 1'b0) begin n_fail++; $display("FAIL frame_release got=%b exp=0", Rx_busy); end
    endtask

    task automatic test_short_frame();
        int base;
        base = done_q.size();
        N_bits = 4'd5;
        send_frame(8'hF5, 5, 1'b1, -1);
        wait_ticks(4);
        n_cmp++; if (Message_out !== 8'h15) begin n_fail++; $display("FAIL short5 got=%h exp=15", Message_out); end
        N_bits = 4'hF;
        send_frame(8'hC3, 8, 1'b1, 5);
        wait_ticks(4);
        n_cmp++; if (Message_out !== 8'hC3) begin n_fail++; $display("FAIL clamp got=%h exp=c3", Message_out); end
        n_cmp++; if (done_q.size() !== base + 2) begin n_fail++; $display("FAIL short_count got=%0d exp=%0d", done_q.size(), base + 2); end
    endtask

    task automatic test_reset_mid();
        int base, fb;
        base = done_q.size(); fb = ferr_cnt;
        N_bits = 4'd8;
        Rx_in = 1'b0;
        wait_ticks(16 + 3 * 16 + 8);
        n_cmp++; if (Rx_busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_pre got=%b exp=1", Rx_busy); end
        reset = 1'b1;
        @(negedge clock);
        n_cmp++; if (Message_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_msg got=%h exp=00", Message_out); end
        n_cmp++; if (Rx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got=%b exp=0", Rx_busy); end
        reset = 1'b0;
        Rx_in = 1'b1;
        wait_ticks(20);
        send_frame(8'h52, 8, 1'b1, -1);
        wait_ticks(4);
        n_cmp++; if (done_q.size() !== base + 1) begin n_fail++; $display("FAIL rstmid_count got=%0d exp=%0d", done_q.size(), base + 1); end
        else begin
            n_cmp++; if (done_q[base] !== 8'h52) begin n_fail++; $display("FAIL rstmid_data got=%h exp=52", done_q[base]); end
        end
        n_cmp++; if (ferr_cnt !== fb) begin n_fail++; $display("FAIL rstmid_ferr got=%0d exp=%0d", ferr_cnt, fb); end
    endtask

    task automatic test_random();
        int base, fb, n, e;
        logic [7:0] d, exp_b;
        fb = ferr_cnt;
        for (int it = 0; it < 12; it++) begin
            base = done_q.size();
            d = 8'($urandom);
            n = $urandom_range(0, 15);
            N_bits = 4'(n);
            e = eff_nb(n);
            exp_b = d & 8'((1 << e) - 1);
            send_frame(d, e, 1'b1, -1);
            wait_ticks($urandom_range(1, 3));
            n_cmp++; if (done_q.size() !== base + 1) begin n_fail++; $display("FAIL rand_count it=%0d got=%0d exp=%0d", it, done_q.size(), base + 1); end
            else begin
                n_cmp++; if (done_q[base] !== exp_b) begin n_fail++; $display("FAIL rand_data it=%0d nb=%0d got=%h exp=%h", it, n, done_q[base], exp_b); end
            end
        end
        n_cmp++; if (ferr_cnt !== fb) begin n_fail++; $display("FAIL rand_ferr got=%0d exp=%0d", ferr_cnt, fb); end
        n_cmp++; if (viol_cnt !== 0) begin n_fail++; $display("FAIL pulse_rules got=%0d exp=0", viol_cnt); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_back_to_back();
        test_glitch();
        test_framing();
        test_short_frame();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
